// File: rtl/rca_block.sv
// BLK-bit ripple-carry adder built from per-bit full-adder equations.
module rca_block #(
  parameter int unsigned BLK = 2
) (
  input  logic [BLK-1:0] a,
  input  logic [BLK-1:0] b,
  input  logic           ci,
  output logic [BLK-1:0] s,
  output logic           co
);

  logic [BLK:0] c;

  // Ripple the carry bit by bit through full-adder cells.
  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int k = 0; k < int'(BLK); k++) begin
      s[k]   = a[k] ^ b[k] ^ c[k];
      c[k+1] = (a[k] & b[k]) | (c[k] & (a[k] ^ b[k]));
    end
  end

  assign co = c[BLK];

endmodule

// File: rtl/carry_select_adder.sv
// Registered carry-select adder: {cout,S} = A + B + cin, one clock of latency.
// Block 0 ripples from cin; each later block precomputes sums for carry-in 0
// and 1 and picks one with the previous block's selected carry.
module carry_select_adder #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned BLK   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  input  logic             in_valid,
  output logic [WIDTH-1:0] S,
  output logic             cout,
  output logic             out_valid
);

  localparam int unsigned NB = WIDTH / BLK;

  if ((WIDTH % BLK) != 0) begin : g_bad_blk
    $error("WIDTH must be a multiple of BLK");
  end

  // carry[i] is the selected carry into block i; carry[NB] is the final carry.
  logic [NB:0]      carry;
  logic [WIDTH-1:0] sum;

  assign carry[0] = cin;

  for (genvar i = 0; i < int'(NB); i++) begin : g_blk
    if (i == 0) begin : g_first
      rca_block #(
        .BLK (BLK)
      ) u_rca (
        .a  (A[BLK-1:0]),
        .b  (B[BLK-1:0]),
        .ci (carry[0]),
        .s  (sum[BLK-1:0]),
        .co (carry[1])
      );
    end else begin : g_sel
      logic [BLK-1:0] s0, s1;
      logic           c0, c1;

      rca_block #(
        .BLK (BLK)
      ) u_rca0 (
        .a  (A[i*BLK +: BLK]),
        .b  (B[i*BLK +: BLK]),
        .ci (1'b0),
        .s  (s0),
        .co (c0)
      );

      rca_block #(
        .BLK (BLK)
      ) u_rca1 (
        .a  (A[i*BLK +: BLK]),
        .b  (B[i*BLK +: BLK]),
        .ci (1'b1),
        .s  (s1),
        .co (c1)
      );

      assign sum[i*BLK +: BLK] = carry[i] ? s1 : s0;
      assign carry[i+1]        = carry[i] ? c1 : c0;
    end
  end

  // Output register: reset wins, valid input loads, otherwise hold the sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      S         <= '0;
      cout      <= 1'b0;
      out_valid <= 1'b0;
    end else if (in_valid) begin
      S         <= sum;
      cout      <= carry[NB];
      out_valid <= 1'b1;
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_carry_select_adder.sv
// Self-checking bench: directed cases and exhaustive sweep at 4/2, randomized
// vectors with idle cycles and X inputs at 32/4 and 16/16.
module tb_carry_select_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic [3:0]  a4, b4, s4;
  logic        c4, v4, co4, ov4;
  logic [31:0] a32, b32, s32;
  logic        c32, v32, co32, ov32;
  logic [15:0] a16, b16, s16;
  logic        c16, v16, co16, ov16;

  int n_vec = 0;
  int n_err = 0;

  carry_select_adder #(.WIDTH(4), .BLK(2)) u_w4 (
    .clk (clk), .rst (rst), .A (a4), .B (b4), .cin (c4), .in_valid (v4),
    .S (s4), .cout (co4), .out_valid (ov4)
  );

  carry_select_adder #(.WIDTH(32), .BLK(4)) u_w32 (
    .clk (clk), .rst (rst), .A (a32), .B (b32), .cin (c32), .in_valid (v32),
    .S (s32), .cout (co32), .out_valid (ov32)
  );

  carry_select_adder #(.WIDTH(16), .BLK(16)) u_w16 (
    .clk (clk), .rst (rst), .A (a16), .B (b16), .cin (c16), .in_valid (v16),
    .S (s16), .cout (co16), .out_valid (ov16)
  );

  task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [32:0] e32;
  logic [16:0] e16;
  int          e4;

  initial begin
    rst = 1'b1;
    v4 = 1'b1; a4 = 4'h8; b4 = 4'h8; c4 = 1'b1;
    v32 = 1'b1; a32 = 32'hffff_ffff; b32 = 32'h1; c32 = 1'b1;
    v16 = 1'b1; a16 = 16'hffff; b16 = 16'h1; c16 = 1'b1;
    e32 = '0;
    e16 = '0;
    tick();
    check("rst_w4_sum", 65'({co4, s4}), 65'(0));
    check("rst_w4_ov", 65'(ov4), 65'(0));
    check("rst_w32_sum", 65'({co32, s32}), 65'(0));
    check("rst_w32_ov", 65'(ov32), 65'(0));
    check("rst_w16_sum", 65'({co16, s16}), 65'(0));
    check("rst_w16_ov", 65'(ov16), 65'(0));

    rst = 1'b0;
    v32 = 1'b0;
    v16 = 1'b0;

    // First valid cycle after reset, no warm-up.
    a4 = 4'hF; b4 = 4'h1; c4 = 1'b0;
    tick();
    check("f_plus_1", 65'({co4, s4}), 65'(5'h10));
    check("f_plus_1_ov", 65'(ov4), 65'(1));

    a4 = 4'hF; b4 = 4'hF; c4 = 1'b1;
    tick();
    check("f_plus_f_plus_1", 65'({co4, s4}), 65'(5'h1F));

    a4 = 4'hF; b4 = 4'h0; c4 = 1'b1;
    tick();
    check("f_plus_0_plus_1", 65'({co4, s4}), 65'(5'h10));

    a4 = 4'h0; b4 = 4'h0; c4 = 1'b0;
    tick();
    check("zero", 65'({co4, s4}), 65'(0));

    // Hold behaviour with in_valid low, including X inputs.
    a4 = 4'h3; b4 = 4'h4; c4 = 1'b0;
    tick();
    check("hold_load", 65'({co4, s4}), 65'(5'h07));
    v4 = 1'b0; a4 = 4'hA; b4 = 4'h9;
    tick();
    check("hold_sum", 65'({co4, s4}), 65'(5'h07));
    check("hold_ov", 65'(ov4), 65'(0));
    a4 = 'x; b4 = 'x; c4 = 1'bx;
    tick();
    check("hold_x_sum", 65'({co4, s4}), 65'(5'h07));
    check("hold_x_ov", 65'(ov4), 65'(0));

    // Reset mid-stream discards a simultaneous valid input.
    rst = 1'b1; v4 = 1'b1; a4 = 4'h8; b4 = 4'h8; c4 = 1'b0;
    tick();
    check("midrst_sum", 65'({co4, s4}), 65'(0));
    check("midrst_ov", 65'(ov4), 65'(0));
    rst = 1'b0; a4 = 4'h5; b4 = 4'h6; c4 = 1'b1;
    tick();
    check("after_rst_sum", 65'({co4, s4}), 65'(5'h0C));
    check("after_rst_ov", 65'(ov4), 65'(1));

    // Exhaustive sweep, back-to-back valid.
    for (int c = 0; c < 2; c++) begin
      for (int a = 0; a < 16; a++) begin
        for (int b = 0; b < 16; b++) begin
          a4 = 4'(a); b4 = 4'(b); c4 = 1'(c);
          e4 = a + b + c;
          tick();
          check("exh_w4", 65'({co4, s4}), 65'(e4));
          check("exh_w4_ov", 65'(ov4), 65'(1));
        end
      end
    end
    v4 = 1'b0;

    // Randomized: occasional idle cycles with X inputs must not disturb outputs.
    for (int n = 0; n < 10000; n++) begin
      v32 = ($urandom_range(0, 3) != 0);
      if (v32) begin
        a32 = $urandom; b32 = $urandom; c32 = 1'($urandom);
        e32 = {1'b0, a32} + {1'b0, b32} + 33'(c32);
      end else begin
        a32 = 'x; b32 = 'x; c32 = 1'bx;
      end
      v16 = ($urandom_range(0, 3) != 0);
      if (v16) begin
        a16 = 16'($urandom); b16 = 16'($urandom); c16 = 1'($urandom);
        e16 = {1'b0, a16} + {1'b0, b16} + 17'(c16);
      end else begin
        a16 = 'x; b16 = 'x; c16 = 1'bx;
      end
      tick();
      check("rnd_w32", 65'({co32, s32}), 65'(e32));
      check("rnd_w32_ov", 65'(ov32), 65'(v32));
      check("rnd_w16", 65'({co16, s16}), 65'(e16));
      check("rnd_w16_ov", 65'(ov16), 65'(v16));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/carry_select_adder.md
CARRY_SELECT_ADDER -- requirements
Module: carry_select_adder

Interface
REQ-001 The block SHALL have exactly one clock and one reset; reset is synchronous and active-high.
REQ-002 Parameter WIDTH, default 4: operand and sum width in bits, legal values 4..64.
REQ-003 Parameter BLK, default 2: carry-select block width in bits; WIDTH SHALL be an integer multiple of BLK, BLK >= 1.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 A  input  WIDTH  unsigned operand A.
REQ-007 B  input  WIDTH  unsigned operand B.
REQ-008 cin  input  1  carry in.
REQ-009 in_valid  input  1  A, B and cin are valid this cycle.
REQ-010 S  output  WIDTH  registered sum, bits [WIDTH-1:0] of A+B+cin.
REQ-011 cout  output  1  registered carry out, bit WIDTH of A+B+cin.
REQ-012 out_valid  output  1  S/cout were updated at the last clock edge.

Function
REQ-013 {cout,S} SHALL equal A+B+cin, evaluated as an unsigned (WIDTH+1)-bit sum; no overflow is lost.
REQ-014 The datapath SHALL be a carry-select structure of WIDTH/BLK blocks:
- block 0: a single BLK-bit ripple adder fed by cin;
- each later block: two BLK-bit ripple adders, with fixed carry-in 0 and 1;
- a 2:1 mux selects that block's sum and carry from the previous block's selected carry-out.
REQ-015 The last block's selected carry SHALL drive cout.
REQ-016 Latency SHALL be exactly one clock. On the rising edge where in_valid=1 and rst=0:
- S and cout register the sum of that cycle's inputs;
- out_valid is set to 1 on the same edge.
REQ-017 On an edge where in_valid=0 and rst=0, S and cout SHALL hold their previous values and out_valid SHALL be 0.
REQ-018 Back-to-back in_valid=1 cycles SHALL produce one result per cycle with no bubbles; there is no backpressure.
REQ-019 Boundary values SHALL be exact:
- all-ones + all-ones + 1 gives S = all-ones, cout = 1;
- all-ones + 0 + 1 gives S = 0, cout = 1;
- 0 + 0 + 0 gives S = 0, cout = 0.
REQ-020 X or Z inputs while in_valid=0 SHALL NOT affect the outputs.

Reset
REQ-021 While rst=1 at a rising edge, S, cout and out_valid SHALL become 0, regardless of in_valid.
REQ-022 Reset SHALL take priority over a simultaneous in_valid=1; that input is discarded.
REQ-023 On the first edge with rst=0 and in_valid=1, the block SHALL register a valid result, with no warm-up cycles.

Structure
REQ-024 No shared package is required; WIDTH and BLK are module parameters only.
REQ-025 One sub-module, rca_block: a parameterised BLK-bit ripple-carry adder built from full-adder equations (a, b, ci in; s, co out). It SHALL be instantiated 2*(WIDTH/BLK)-1 times through a generate loop.
REQ-026 The carry-select core SHALL be purely combinational; the only state is the S/cout/out_valid output register.

Verification
REQ-027 Exhaustive check at WIDTH=4, BLK=2: all 16x16 A,B pairs with cin=0, then with cin=1, in_valid=1 every cycle. Required: {cout,S} = A+B+cin one cycle later; error count 0.
REQ-028 A=4'hF, B=4'h1, cin=0 -> next cycle S=4'h0, cout=1, out_valid=1.
REQ-029 A=4'hF, B=4'hF, cin=1 -> next cycle S=4'hF, cout=1.
REQ-030 Hold: register A=4'h3, B=4'h4, cin=0 (S=4'h7). Then drop in_valid and change inputs to A=4'hA, B=4'h9. Required: S stays 4'h7, cout stays 0, out_valid=0.
REQ-031 Reset mid-stream: assert rst with in_valid=1, A=4'h8, B=4'h8 -> next edge S=0, cout=0, out_valid=0. Release rst -> next valid input is registered correctly.
REQ-032 Randomised check at WIDTH=32, BLK=4 and WIDTH=16, BLK=16: at least 10000 vectors against a behavioural adder, zero mismatches.
